iod_dly_tap_responder: RTL and testbench



---
 rtl/iod_tap_resp_pkg.sv | 18 +
 rtl/iod_tap_resp_lfsr.sv | 29 ++
 rtl/iod_dly_tap_responder.sv | 130 +++++++++++++
 tb/tb_iod_dly_tap_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/iod_tap_resp_pkg.sv
// Shared types and constants for the IOD delay-tap responder.
// The LFSR constants are used only when IOD_TAP_RESP_JITTER_EN is defined.
package iod_tap_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EVAL   = 2'd2
  } tap_state_e;

  localparam int DEF_TAP_WIDTH = 8;
  localparam int DEF_TAP_MAX   = 127;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/iod_tap_resp_lfsr.sv
// 16-bit Galois LFSR with enable and synchronous reset to LFSR_SEED.
// Supplies the marginal-sampling coin flips when IOD_TAP_RESP_JITTER_EN is defined.
module iod_tap_resp_lfsr
  import iod_tap_resp_pkg::*;
(
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (en_i) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/iod_dly_tap_responder.sv
// Far-end responder for bit-alignment tap commands: tap counter, settle delay, sticky eye flags.
// Define IOD_TAP_RESP_JITTER_EN to randomise flag evaluation one tap outside either eye edge.
module iod_dly_tap_responder
  import iod_tap_resp_pkg::*;
#(
  parameter int TAP_WIDTH     = DEF_TAP_WIDTH,
  parameter int TAP_MAX       = DEF_TAP_MAX,
  parameter int SETTLE_CYCLES = 4,
  parameter int LOAD_TAP      = 0
) (
  input  logic                 SCLK,
  input  logic                 RESET,
  input  logic                 BIT_ALGN_LOAD,
  input  logic                 BIT_ALGN_MOVE,
  input  logic                 BIT_ALGN_DIR,
  input  logic                 BIT_ALGN_CLR_FLGS,
  input  logic [TAP_WIDTH-1:0] EYE_LO,
  input  logic [TAP_WIDTH-1:0] EYE_HI,
  output logic                 IOD_EARLY,
  output logic                 IOD_LATE,
  output logic                 IOD_OOR,
  output logic [TAP_WIDTH-1:0] TAP_VAL,
  output logic                 BUSY
);

  localparam logic [TAP_WIDTH-1:0] TAP_MAX_V  = TAP_WIDTH'(TAP_MAX);
  localparam logic [TAP_WIDTH-1:0] LOAD_TAP_V = TAP_WIDTH'(LOAD_TAP);
  localparam logic [TAP_WIDTH-1:0] TAP_ONE    = TAP_WIDTH'(1);
  localparam logic [3:0]           SETTLE_V   = 4'(SETTLE_CYCLES);

  tap_state_e           state_q;
  logic [3:0]           cnt_q;
  logic [TAP_WIDTH-1:0] tap_q;
  logic                 early_q;
  logic                 late_q;
  logic                 oor_q;
  logic                 busy_q;

  logic                 early_hit_d;
  logic                 late_hit_d;
  logic                 at_limit_d;

`ifdef IOD_TAP_RESP_JITTER_EN
  logic [15:0] lfsr;

  iod_tap_resp_lfsr u_lfsr (
    .clk_i  (SCLK),
    .srst_i (RESET),
    .en_i   (1'b1),
    .lfsr_o (lfsr)
  );
`endif

  always_comb begin
    early_hit_d = (tap_q < EYE_LO);
    late_hit_d  = (tap_q > EYE_HI);
`ifdef IOD_TAP_RESP_JITTER_EN
    // One tap outside the eye edge is a coin flip; the wrapped compare is harmless at 0/max.
    if (tap_q == (EYE_LO - TAP_ONE)) early_hit_d = early_hit_d & lfsr[0];
    if (tap_q == (EYE_HI + TAP_ONE)) late_hit_d  = late_hit_d & lfsr[1];
`endif
    at_limit_d = BIT_ALGN_DIR ? (tap_q == TAP_MAX_V) : (tap_q == '0);
  end

  // Later assignments in this block override the CLR_FLGS clear, giving set-wins ordering.
  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tap_q   <= LOAD_TAP_V;
      early_q <= 1'b0;
      late_q  <= 1'b0;
      oor_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (BIT_ALGN_CLR_FLGS) begin
        early_q <= 1'b0;
        late_q  <= 1'b0;
        oor_q   <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (BIT_ALGN_LOAD) begin
            tap_q   <= LOAD_TAP_V;
            early_q <= 1'b0;
            late_q  <= 1'b0;
            cnt_q   <= 4'd1;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end else if (BIT_ALGN_MOVE) begin
            if (at_limit_d) begin
              oor_q <= 1'b1;
            end else begin
              tap_q   <= BIT_ALGN_DIR ? tap_q + TAP_ONE : tap_q - TAP_ONE;
              cnt_q   <= 4'd1;
              busy_q  <= 1'b1;
              state_q <= ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_q >= SETTLE_V) begin
            cnt_q   <= '0;
            state_q <= ST_EVAL;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_EVAL: begin
          early_q <= (early_q & ~BIT_ALGN_CLR_FLGS) | early_hit_d;
          late_q  <= (late_q & ~BIT_ALGN_CLR_FLGS) | late_hit_d;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign TAP_VAL   = tap_q;
  assign IOD_EARLY = early_q;
  assign IOD_LATE  = late_q;
  assign IOD_OOR   = oor_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_iod_dly_tap_responder.sv
// Bench for iod_dly_tap_responder: fixed vector table, directed corner sequences and
// randomised traffic against a transaction-level model (a busy countdown and sticky flags).
module tb_iod_dly_tap_responder;

  localparam int TW   = 8;
  localparam int TMAX = 127;
  localparam int SC   = 4;
  localparam int LT   = 0;

  logic          SCLK = 1'b0;
  logic          RESET = 1'b1;
  logic          ld = 1'b0, mv = 1'b0, dir = 1'b0, clr = 1'b0;
  logic [TW-1:0] lo = 8'd40, hi = 8'd80;
  logic          IOD_EARLY, IOD_LATE, IOD_OOR, BUSY;
  logic [TW-1:0] TAP_VAL;

  always #5 SCLK = ~SCLK;

  iod_dly_tap_responder #(
    .TAP_WIDTH(TW), .TAP_MAX(TMAX), .SETTLE_CYCLES(SC), .LOAD_TAP(LT)
  ) dut (
    .SCLK(SCLK), .RESET(RESET),
    .BIT_ALGN_LOAD(ld), .BIT_ALGN_MOVE(mv), .BIT_ALGN_DIR(dir), .BIT_ALGN_CLR_FLGS(clr),
    .EYE_LO(lo), .EYE_HI(hi),
    .IOD_EARLY(IOD_EARLY), .IOD_LATE(IOD_LATE), .IOD_OOR(IOD_OOR),
    .TAP_VAL(TAP_VAL), .BUSY(BUSY)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_model = 1'b1;

  // Reference state: tap, sticky flags, and cycles left until the evaluation completes.
  int m_tap = LT;
  bit m_e = 0, m_l = 0, m_o = 0;
  int m_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    if (RESET) begin
      m_tap = LT; m_e = 0; m_l = 0; m_o = 0; m_left = 0;
      return;
    end
    if (clr) begin m_e = 0; m_l = 0; m_o = 0; end
    if (m_left == 0) begin
      if (ld) begin
        m_tap = LT; m_e = 0; m_l = 0; m_left = SC + 1;
      end else if (mv) begin
        if ((dir && m_tap == TMAX) || (!dir && m_tap == 0)) m_o = 1;
        else begin
          m_tap  = dir ? m_tap + 1 : m_tap - 1;
          m_left = SC + 1;
        end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_tap < int'(lo)) m_e = 1;
        if (m_tap > int'(hi)) m_l = 1;
      end
    end
  endtask

  task automatic tick(input bit r, input bit l, input bit m, input bit d, input bit c, input string tag);
    logic [11:0] exp_v;
    RESET = r; ld = l; mv = m; dir = d; clr = c;
    model_edge();
    @(posedge SCLK);
    #1;
    RESET = 0; ld = 0; mv = 0; clr = 0;
    exp_v = {m_tap[7:0], (m_left != 0), m_e, m_l, m_o};
    if (chk_model)
      check({tag, "_model"}, {20'h0, TAP_VAL, BUSY, IOD_EARLY, IOD_LATE, IOD_OOR}, {20'h0, exp_v});
  endtask

  task automatic idle(input string tag);
    tick(0, 0, 0, 0, 0, tag);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && BUSY; i++) idle(tag);
    check({tag, "_busy_timeout"}, {31'h0, BUSY}, 32'h0);
  endtask

  task automatic step(input bit d, input string tag);
    tick(0, 0, 1, d, 0, tag);
    wait_idle(tag);
  endtask

  typedef struct {
    bit r, l, m, d, c;
    logic [7:0] lo, hi;
    logic [7:0] tap;
    bit busy, e, lt, o;
  } vec_t;

  vec_t tbl[16];
  int   early_cnt;

  initial begin
    //          r  l  m  d  c   lo     hi     tap   bsy e lt o
    tbl[0]  = '{1, 0, 0, 0, 0, 8'd40, 8'd80, 8'd0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 8'd40, 8'd80, 8'd0, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 8'd40, 8'd80, 8'd0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 8'd40, 8'd80, 8'd0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 8'd40, 8'd80, 8'd0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 8'd40, 8'd80, 8'd0, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 8'd40, 8'd80, 8'd0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 0, 8'd40, 8'd80, 8'd0, 0, 1, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 1, 8'd40, 8'd80, 8'd0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 1, 1, 1, 8'd40, 8'd80, 8'd1, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 1, 0, 8'd40, 8'd80, 8'd1, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 8'd40, 8'd80, 8'd1, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 8'd40, 8'd80, 8'd1, 1, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 1, 8'd40, 8'd80, 8'd1, 1, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 8'd0,  8'd0,  8'd1, 0, 0, 1, 0};
    tbl[15] = '{0, 1, 0, 0, 1, 8'd0,  8'd0,  8'd0, 1, 0, 0, 0};

`ifdef IOD_TAP_RESP_JITTER_EN
    chk_model = 1'b0;
`endif

    for (int i = 0; i < 16; i++) begin
      lo = tbl[i].lo;
      hi = tbl[i].hi;
      tick(tbl[i].r, tbl[i].l, tbl[i].m, tbl[i].d, tbl[i].c, $sformatf("vec%0d", i));
      check($sformatf("vec%0d", i),
            {20'h0, TAP_VAL, BUSY, IOD_EARLY, IOD_LATE, IOD_OOR},
            {20'h0, tbl[i].tap, tbl[i].busy, tbl[i].e, tbl[i].lt, tbl[i].o});
    end

    // Walk to 60, clearing flags before the final move.
    lo = 8'd40; hi = 8'd80;
    tick(1, 0, 0, 0, 0, "rst_a");
    for (int i = 0; i < 59; i++) step(1, "walk60");
    tick(0, 0, 0, 0, 1, "clr60");
    step(1, "walk60_last");
    check("tap60", {24'h0, TAP_VAL}, 32'd60);
    check("tap60_flags", {29'h0, IOD_EARLY, IOD_LATE, IOD_OOR}, 32'h0);

    // Saturate at TAP_MAX.
    for (int i = 60; i < TMAX; i++) step(1, "walk127");
    tick(0, 0, 1, 1, 0, "oor_hi");
    check("oor_hi_flag", {31'h0, IOD_OOR}, 32'h1);
    check("oor_hi_tap", {24'h0, TAP_VAL}, 32'd127);
    check("oor_hi_busy", {31'h0, BUSY}, 32'h0);
    tick(0, 0, 0, 0, 1, "oor_clr");
    check("oor_cleared", {31'h0, IOD_OOR}, 32'h0);

    // A MOVE issued while busy is dropped.
    tick(0, 0, 1, 0, 0, "dbl_mv1");
    idle("dbl_gap");
    tick(0, 0, 1, 0, 0, "dbl_mv2");
    wait_idle("dbl");
    check("dbl_move_tap", {24'h0, TAP_VAL}, 32'd126);

    // Underflow attempt with simultaneous clear: set wins.
    tick(0, 1, 0, 0, 0, "load0");
    wait_idle("load0");
    tick(0, 0, 1, 0, 1, "oor_lo_clr");
    check("oor_lo_set_wins", {31'h0, IOD_OOR}, 32'h1);
    check("oor_lo_tap", {24'h0, TAP_VAL}, 32'd0);

    // Reset during the second settle cycle after moving to 81.
    tick(1, 0, 0, 0, 0, "rst_b");
    for (int i = 0; i < 80; i++) step(1, "walk80");
    tick(0, 0, 0, 0, 1, "clr80");
    tick(0, 0, 1, 1, 0, "mv81");
    check("mv81_tap", {24'h0, TAP_VAL}, 32'd81);
    idle("settle2");
    tick(1, 0, 0, 0, 0, "rst_mid");
    check("rst_mid_state", {20'h0, TAP_VAL, BUSY, IOD_EARLY, IOD_LATE, IOD_OOR}, 32'h0);
    for (int i = 0; i < SC + 2; i++) begin
      idle("post_rst");
      check("post_rst_late", {31'h0, IOD_LATE}, 32'h0);
    end

    // Evaluation rate one tap below the eye.
    lo = 8'd40; hi = 8'd80;
    for (int i = 0; i < 39; i++) step(1, "walk39");
    early_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick(0, 0, 0, 0, 1, "rate_clr");
      step(1, "rate_up");
      step(0, "rate_dn");
      if (IOD_EARLY) early_cnt++;
    end
`ifdef IOD_TAP_RESP_JITTER_EN
    check("jitter_rate_in_band", {31'h0, (early_cnt >= 60 && early_cnt <= 140)}, 32'h1);
`else
    check("early_rate", early_cnt, 32'd200);
`endif

    // Randomised traffic against the reference model.
    tick(1, 0, 0, 0, 0, "rst_rand");
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] a, b;
      if ($urandom_range(0, 49) == 0) begin
        a = 8'($urandom_range(0, 140));
        b = 8'($urandom_range(0, 140));
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
      end
      tick($urandom_range(0, 299) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) < 60,
           $urandom_range(0, 14) == 0,
           "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
